// File: rtl/fm_wm_pkg.sv
// Shared types and constants for the FM x WM transformation stage.
package fm_wm_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_W,
        READ_F,
        WRITE,
        NEXT_W,
        DONE
    } state_t;

    localparam int ADDRESS_WIDTH = 13;
    localparam logic [ADDRESS_WIDTH-1:0] WEIGHT_BASE_ADDR  = 13'h000;
    localparam logic [ADDRESS_WIDTH-1:0] FEATURE_BASE_ADDR = 13'h200;

endpackage

// File: rtl/fm_wm_wrap_counter.sv
// Modulo-MAX counter with enable, synchronous clear and terminal flag.
// Wraps by explicit compare so MAX need not be a power of two.
module fm_wm_wrap_counter #(
    parameter int MAX   = 4,
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             clear,
    output logic [WIDTH-1:0] count,
    output logic             terminal
);

    localparam logic [WIDTH-1:0] LAST = WIDTH'(MAX - 1);

    // Count register: reset/clear to zero, otherwise step and wrap at LAST.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (enable) begin
            if (count == LAST) begin
                count <= '0;
            end else begin
                count <= count + WIDTH'(1);
            end
        end
    end

    assign terminal = (count == LAST);

endmodule

// File: rtl/fm_wm_transformation_fsm.sv
// Sequencing controller for the FM x WM transformation stage.
// For each weight column: load the column into the scratch pad, then for
// every feature row read the row and write one product word.
// Optional build macro FM_WM_STALL_EN adds a mem_stall input that freezes
// the sequence and suppresses all strobes while asserted.
module fm_wm_transformation_fsm #(
    parameter int FEATURE_ROWS          = 6,
    parameter int WEIGHT_COLS           = 3,
    parameter int COUNTER_FEATURE_WIDTH = $clog2(FEATURE_ROWS),
    parameter int COUNTER_WEIGHT_WIDTH  = $clog2(WEIGHT_COLS)
) (
    input  logic                             clk,
    input  logic                             reset,
`ifdef FM_WM_STALL_EN
    input  logic                             mem_stall,
`endif
    input  logic                             start,
    output logic                             enable_weight_count,
    output logic                             enable_feature_count,
    output logic                             enable_scratch_pad,
    output logic                             read_feature_or_weight,
    output logic                             enable_write_fm_wm_prod,
    output logic [COUNTER_FEATURE_WIDTH-1:0] fm_wm_row_wr_addr,
    output logic [COUNTER_WEIGHT_WIDTH-1:0]  fm_wm_col_wr_addr,
    output logic                             busy,
    output logic                             done
);

    import fm_wm_pkg::*;

    state_t                           state;
    state_t                           next_state;
    logic                             stall;
    logic                             row_inc;
    logic                             col_inc;
    logic                             cnt_clear;
    logic                             row_last;
    logic                             col_last;
    logic [COUNTER_FEATURE_WIDTH-1:0] row_cnt;
    logic [COUNTER_WEIGHT_WIDTH-1:0]  col_cnt;

`ifdef FM_WM_STALL_EN
    assign stall = mem_stall;
`else
    assign stall = 1'b0;
`endif

    // Idle keeps both counters parked at zero so a fresh run starts clean.
    assign cnt_clear = (state == IDLE);

    fm_wm_wrap_counter #(
        .MAX   (FEATURE_ROWS),
        .WIDTH (COUNTER_FEATURE_WIDTH)
    ) u_row_counter (
        .clk      (clk),
        .reset    (reset),
        .enable   (row_inc),
        .clear    (cnt_clear),
        .count    (row_cnt),
        .terminal (row_last)
    );

    fm_wm_wrap_counter #(
        .MAX   (WEIGHT_COLS),
        .WIDTH (COUNTER_WEIGHT_WIDTH)
    ) u_col_counter (
        .clk      (clk),
        .reset    (reset),
        .enable   (col_inc),
        .clear    (cnt_clear),
        .count    (col_cnt),
        .terminal (col_last)
    );

    // State register; reset aborts any run in progress.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and Moore output decode; a stall freezes everything and
    // masks the strobes while leaving the level outputs state-decoded.
    always_comb begin
        next_state              = state;
        enable_weight_count     = 1'b0;
        enable_feature_count    = 1'b0;
        enable_scratch_pad      = 1'b0;
        read_feature_or_weight  = 1'b0;
        enable_write_fm_wm_prod = 1'b0;
        busy                    = 1'b0;
        done                    = 1'b0;
        row_inc                 = 1'b0;
        col_inc                 = 1'b0;

        unique case (state)
            IDLE: begin
                if (start) begin
                    next_state = LOAD_W;
                end
            end
            LOAD_W: begin
                enable_scratch_pad = 1'b1;
                busy               = 1'b1;
                next_state         = READ_F;
            end
            READ_F: begin
                enable_feature_count   = 1'b1;
                read_feature_or_weight = 1'b1;
                busy                   = 1'b1;
                next_state             = WRITE;
            end
            WRITE: begin
                enable_write_fm_wm_prod = 1'b1;
                read_feature_or_weight  = 1'b1;
                busy                    = 1'b1;
                row_inc                 = 1'b1;
                next_state              = row_last ? NEXT_W : READ_F;
            end
            NEXT_W: begin
                enable_weight_count = 1'b1;
                busy                = 1'b1;
                col_inc             = 1'b1;
                next_state          = col_last ? DONE : LOAD_W;
            end
            DONE: begin
                done = 1'b1;
                if (!start) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase

        if (stall) begin
            next_state              = state;
            enable_weight_count     = 1'b0;
            enable_feature_count    = 1'b0;
            enable_scratch_pad      = 1'b0;
            enable_write_fm_wm_prod = 1'b0;
            row_inc                 = 1'b0;
            col_inc                 = 1'b0;
        end
    end

    assign fm_wm_row_wr_addr = row_cnt;
    assign fm_wm_col_wr_addr = col_cnt;

endmodule
